ripple_carry_adder4: RTL and testbench

- Registered WIDTH-bit binary adder (default 4) with carry-in and carry-out.
- Built as an explicit ripple chain of 1-bit full adders; the vector "+" operator is not used for the sum datapath.
- One-cycle registered result with a valid strobe.
- Used as a leaf arithmetic primitive wherever a small adder with carry chaining is needed.

---
 rtl/ripple_carry_adder4.sv | 72 +++++++
 tb/tb_ripple_carry_adder4.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ripple_carry_adder4.sv
// ripple_carry_adder4: registered WIDTH-bit adder built from an explicit chain
// of 1-bit full adders, with carry-in, carry-out and a one-cycle valid strobe.
// Optional feature: define RCA_OVERFLOW_EN to add a registered two's-complement
// signed overflow output.
module ripple_carry_adder4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef RCA_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] s,
  output logic             carry_out,
  output logic             out_valid
);

  // Stage p0: combinational ripple chain straight from the input pins.
  logic [WIDTH-1:0] sum_p0;
  logic             carry_p0;
  logic             carry_msb_in_p0;

  // Ripple the carry bit by bit; a single running variable keeps the chain
  // free of self-referencing vector bits.
  always_comb begin
    logic c;
    sum_p0          = '0;
    carry_msb_in_p0 = carry_in;
    c               = carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      carry_msb_in_p0 = c;
      sum_p0[i]       = a[i] ^ b[i] ^ c;
      c               = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    carry_p0 = c;
  end

  // Stage p1: result registers. Reset wins over in_valid; with in_valid low
  // the data registers hold so undriven operands cannot disturb them.
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s         <= sum_p0;
        carry_out <= carry_p0;
      end
    end
  end

`ifdef RCA_OVERFLOW_EN
  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (in_valid) begin
      overflow <= carry_p0 ^ carry_msb_in_p0;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = carry_msb_in_p0;
`endif

endmodule

// File: tb/tb_ripple_carry_adder4.sv
// tb_ripple_carry_adder4: randomized and directed bench for ripple_carry_adder4,
// compared against an integer-arithmetic reference model.
module tb_ripple_carry_adder4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic [W-1:0] s;
  logic         carry_out;
  logic         out_valid;
`ifdef RCA_OVERFLOW_EN
  logic         overflow;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // reference state
  int exp_s  = 0;
  int exp_c  = 0;
  int exp_v  = 0;
  int exp_ov = 0;

  ripple_carry_adder4 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
`ifdef RCA_OVERFLOW_EN
    .overflow (overflow),
`endif
    .s        (s),
    .carry_out(carry_out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, update the model, clock, then compare.
  task automatic step(input logic r, input logic iv, input int ta, input int tb,
                      input int tc, input string tag);
    int total, sa, sb, ssum;
    rst      = r;
    in_valid = iv;
    a        = ta[W-1:0];
    b        = tb[W-1:0];
    carry_in = tc[0];
    if (r) begin
      exp_s = 0; exp_c = 0; exp_v = 0; exp_ov = 0;
    end else begin
      exp_v = iv ? 1 : 0;
      if (iv) begin
        total = ta + tb + tc;
        exp_s = total % (1 << W);
        exp_c = total / (1 << W);
        sa    = (ta >= (1 << (W - 1))) ? ta - (1 << W) : ta;
        sb    = (tb >= (1 << (W - 1))) ? tb - (1 << W) : tb;
        ssum  = sa + sb + tc;
        exp_ov = (ssum > (1 << (W - 1)) - 1 || ssum < -(1 << (W - 1))) ? 1 : 0;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".s"},         32'(s),         32'(exp_s));
    chk({tag, ".carry_out"}, 32'(carry_out), 32'(exp_c));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_v));
`ifdef RCA_OVERFLOW_EN
    chk({tag, ".overflow"},  32'(overflow),  32'(exp_ov));
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0;

    // reset state
    step(1, 0, 0, 0, 0, "reset0");
    step(1, 1, 15, 15, 1, "reset1");

    // first result after reset
    step(0, 1, 0, 0, 0, "zero");

    // back-to-back stream
    step(0, 1, 'b1010, 'b0001, 0, "bb0");
    step(0, 1, 'b1100, 'b0000, 1, "bb1");
    step(0, 1, 'b0101, 'b1010, 1, "bb2_fullprop");
    step(0, 1, 'b0111, 'b1100, 0, "bb3");

    // boundaries
    step(0, 1, 'b1111, 'b1111, 1, "allones");
    step(0, 1, 'b0111, 'b0001, 0, "sovf");

    // hold while in_valid low, with changing and unknown operands
    step(0, 1, 'b1010, 'b0001, 0, "pre_hold");
    for (int i = 0; i < 4; i++)
      step(0, 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 1)), "hold");
    rst = 1'b0; in_valid = 1'b0; a = 'x; b = 'x; carry_in = 1'bx;
    @(posedge clk);
    #1;
    chk("hold_x.s",         32'(s),         32'(exp_s));
    chk("hold_x.carry_out", 32'(carry_out), 32'(exp_c));
    chk("hold_x.out_valid", 32'(out_valid), 32'(0));

    // reset colliding with a valid input
    step(0, 1, 'b0111, 'b1100, 0, "pre_rst");
    step(1, 1, 'b1111, 'b1111, 1, "rst_vs_valid");

    // exhaustive sweep, back-to-back
    for (int x = 0; x < (1 << W); x++)
      for (int y = 0; y < (1 << W); y++)
        for (int ci = 0; ci < 2; ci++)
          step(0, 1, x, y, ci, $sformatf("sweep_%0d_%0d_%0d", x, y, ci));

    // random mix of valid, idle and reset cycles
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 1)), $sformatf("rand%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
